// File: rtl/multi_flop_synchronizer_multi_bits.sv
// multi_flop_synchronizer_multi_bits
// Per-bit N-flop synchronizer bringing a bus of independent level signals
// into the CLK domain. Bits are not kept coherent with each other.
// Optional edge-detect outputs RISE/FALL are built only when the macro
// MULTI_FLOP_SYNC_EDGE_EN is defined; the default build omits them.
module multi_flop_synchronizer_multi_bits #(
  parameter int unsigned                NUM_STAGES  = 2,
  parameter int unsigned                BUS_WIDTH   = 1,
  parameter logic [BUS_WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
`ifdef MULTI_FLOP_SYNC_EDGE_EN
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL
`else
  output logic [BUS_WIDTH-1:0] SYNC
`endif
);

  // Reject illegal configurations at elaboration.
  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("NUM_STAGES out of range (legal 2..8): %0d", NUM_STAGES);
  end
  if (BUS_WIDTH < 1 || BUS_WIDTH > 256) begin : g_bad_bus_width
    $error("BUS_WIDTH out of range (legal 1..256): %0d", BUS_WIDTH);
  end

  // Synchronizer chain; kept as discrete flops so tools neither retime nor
  // pack them into shift-register primitives.
  (* ASYNC_REG = "TRUE" *) logic [BUS_WIDTH-1:0] stage_q [NUM_STAGES];

  // Shift ASYNC through the chain; synchronous reset loads RESET_VALUE everywhere.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= ASYNC;
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // SYNC comes straight off the last flop, no logic in between.
  assign SYNC = stage_q[NUM_STAGES-1];

`ifdef MULTI_FLOP_SYNC_EDGE_EN
  logic [BUS_WIDTH-1:0] prev_q;

  // Remember last SYNC value for edge detection; reset matches the chain so
  // no spurious pulse appears on the first cycle out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= SYNC;
    end
  end

  // Edge pulses are coincident with the first cycle SYNC shows a new value.
  assign RISE = SYNC & ~prev_q;
  assign FALL = ~SYNC & prev_q;
`endif

endmodule

// File: tb/tb_multi_flop_synchronizer_multi_bits.sv
// Self-checking bench for multi_flop_synchronizer_multi_bits.
// Three instances share clock and reset: 2-stage x1, 3-stage x8 and
// 2-stage x4 with a non-zero reset value. A queue per instance holds the
// SYNC values expected after each coming edge. Edge outputs are checked
// when MULTI_FLOP_SYNC_EDGE_EN is defined.
module tb_multi_flop_synchronizer_multi_bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       as2;
  logic [7:0] as3;
  logic [3:0] asr;
  logic       sy2;
  logic [7:0] sy3;
  logic [3:0] syr;

  localparam logic [3:0] RV_R = 4'b1010;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic       q2[$];
  logic [7:0] q3[$];
  logic [3:0] qr[$];

  always #5 clk = ~clk;

`ifdef MULTI_FLOP_SYNC_EDGE_EN
  logic       ri2, fa2;
  logic [7:0] ri3, fa3;
  logic [3:0] rir, far;
  logic       pv2;
  logic [7:0] pv3;
  logic [3:0] pvr;

  multi_flop_synchronizer_multi_bits dut2 (
    .CLK(clk), .RST(rst), .ASYNC(as2), .SYNC(sy2), .RISE(ri2), .FALL(fa2));
  multi_flop_synchronizer_multi_bits #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
    .CLK(clk), .RST(rst), .ASYNC(as3), .SYNC(sy3), .RISE(ri3), .FALL(fa3));
  multi_flop_synchronizer_multi_bits #(.NUM_STAGES(2), .BUS_WIDTH(4),
    .RESET_VALUE(RV_R)) dutr (
    .CLK(clk), .RST(rst), .ASYNC(asr), .SYNC(syr), .RISE(rir), .FALL(far));
`else
  multi_flop_synchronizer_multi_bits dut2 (
    .CLK(clk), .RST(rst), .ASYNC(as2), .SYNC(sy2));
  multi_flop_synchronizer_multi_bits #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
    .CLK(clk), .RST(rst), .ASYNC(as3), .SYNC(sy3));
  multi_flop_synchronizer_multi_bits #(.NUM_STAGES(2), .BUS_WIDTH(4),
    .RESET_VALUE(RV_R)) dutr (
    .CLK(clk), .RST(rst), .ASYNC(asr), .SYNC(syr));
`endif

  task automatic check_eq(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // After a reset edge each output shows its reset value for NUM_STAGES-1
  // further edges before the first sampled ASYNC arrives.
  task automatic refill();
    q2.delete(); q3.delete(); qr.delete();
    q2.push_back(1'b0);
    q3.push_back(8'h00); q3.push_back(8'h00);
    qr.push_back(RV_R);
  endtask

  // Drive inputs on the falling edge, check #1 after the rising edge.
  task automatic tick(input logic r, input logic a2, input logic [7:0] a3,
                      input logic [3:0] ar);
    logic       e2;
    logic [7:0] e3;
    logic [3:0] er;
    @(negedge clk);
    rst = r; as2 = a2; as3 = a3; asr = ar;
    @(posedge clk);
    #1;
    if (r) begin
      e2 = 1'b0; e3 = 8'h00; er = RV_R;
      refill();
    end else begin
      q2.push_back(a2); q3.push_back(a3); qr.push_back(ar);
      e2 = q2.pop_front(); e3 = q3.pop_front(); er = qr.pop_front();
    end
    check_eq("sync_ns2_w1", {7'd0, sy2}, {7'd0, e2});
    check_eq("sync_ns3_w8", sy3, e3);
    check_eq("sync_rv1010", {4'd0, syr}, {4'd0, er});
`ifdef MULTI_FLOP_SYNC_EDGE_EN
    if (r) begin
      pv2 = 1'b0; pv3 = 8'h00; pvr = RV_R;
    end
    check_eq("rise_ns2", {7'd0, ri2}, {7'd0, e2 & ~pv2});
    check_eq("fall_ns2", {7'd0, fa2}, {7'd0, ~e2 & pv2});
    check_eq("rise_ns3", ri3, e3 & ~pv3);
    check_eq("fall_ns3", fa3, ~e3 & pv3);
    check_eq("rise_rv",  {4'd0, rir}, {4'd0, er & ~pvr});
    check_eq("fall_rv",  {4'd0, far}, {4'd0, ~er & pvr});
    pv2 = e2; pv3 = e3; pvr = er;
`endif
  endtask

  initial begin
    rst = 1'b1; as2 = 1'b0; as3 = 8'h00; asr = 4'h0;
    refill();

    // Reset with ASYNC high: outputs take reset values.
    tick(1'b1, 1'b1, 8'hFF, 4'hF);
    check_eq("plan_reset_sync0", {7'd0, sy2}, 8'h00);
    check_eq("plan_reset_rv",    {4'd0, syr}, 8'h0A);

    // Propagation and latency.
    tick(1'b0, 1'b1, 8'hA5, 4'b0101);
    check_eq("plan_prop_1edge",  {7'd0, sy2}, 8'h00);
    check_eq("plan_lat_edge_n",  sy3, 8'h00);
    tick(1'b0, 1'b1, 8'hA5, 4'b0101);
    check_eq("plan_prop_2edge",  {7'd0, sy2}, 8'h01);
    check_eq("plan_lat_edge_n1", sy3, 8'h00);
    check_eq("plan_rv_release",  {4'd0, syr}, 8'h05);
    tick(1'b0, 1'b1, 8'hA5, 4'b0101);
    check_eq("plan_lat_edge_n2", sy3, 8'hA5);

    // Falling transition and mid-stream reset with 8'hFF in flight.
    tick(1'b0, 1'b0, 8'hFF, 4'b0011);
    tick(1'b0, 1'b0, 8'hFF, 4'b0011);
    tick(1'b1, 1'b0, 8'hFF, 4'b0011);
    check_eq("plan_midreset", sy3, 8'h00);
    tick(1'b0, 1'b1, 8'hFF, 4'b1100);
    tick(1'b0, 1'b1, 8'hFF, 4'b1100);
    check_eq("plan_after_rel_2", sy3, 8'h00);
    tick(1'b0, 1'b0, 8'hFF, 4'b1100);
    check_eq("plan_after_rel_3", sy3, 8'hFF);

    // Toggling bit pattern for edge pulses.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'(i % 2), 8'(i * 37), 4'(i));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      tick(($urandom_range(15) == 0), 1'($urandom), 8'($urandom),
           4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_flop_synchronizer_multi_bits.md
# multi_flop_synchronizer_multi_bits

N-stage flip-flop synchronizer for a bus of independent single-bit signals crossing into the `CLK` domain. It sits at every clock-domain entry point for level signals: quasi-static control bits, Gray-coded pointers and asynchronous status flags. Each bit passes through its own chain of NUM_STAGES flops. No cross-bit coherency is provided.

## Interface
- NUM_STAGES, default 2: number of flops per bit. Legal values are 2..8.
- BUS_WIDTH, default 1: number of bits synchronized. Legal values are 1..256.
- RESET_VALUE, default all-zeros (BUS_WIDTH wide): value loaded into every stage on reset.
- CLK  input  1  destination-domain clock. The block has exactly one clock; all flops are rising-edge.
- RST  input  1  reset, synchronous and active-high.
- ASYNC  input  BUS_WIDTH  asynchronous source bus. It may change at any time relative to CLK.
- SYNC  output  BUS_WIDTH  synchronized bus, driven directly by the last stage of each chain.
- RISE  output  BUS_WIDTH  one-cycle pulse per bit on a 0->1 transition of SYNC. Present only with the macro.
- FALL  output  BUS_WIDTH  one-cycle pulse per bit on a 1->0 transition of SYNC. Present only with the macro.

## Operation
- The block holds a stage array stage[0..NUM_STAGES-1] per bit.
- At each rising CLK edge with RST=0:
  - stage[0] <= ASYNC
  - stage[i] <= stage[i-1]
- SYNC = stage[NUM_STAGES-1], with no combinational logic between the last flop and the SYNC port.
- At a rising CLK edge with RST=1, all stages load RESET_VALUE. With the macro, the edge-history register also loads RESET_VALUE. RISE and FALL go to 0.
- Reset has no asynchronous effect. Between RST assertion and the next rising edge, outputs hold their previous value.
- Bits are fully independent. A multi-bit change on ASYNC may show up on SYNC split across two adjacent cycles. Upstream logic must therefore send only Gray-coded or stable-for-NUM_STAGES+1-cycles data.
- Out-of-range NUM_STAGES or BUS_WIDTH must fail at elaboration with a message naming the offending parameter.
- All stage flops carry the synthesis attribute ASYNC_REG="TRUE". They must not be retimed, merged or shift-register-inferred.

## Timing
- Latency:
  - A value stable on ASYNC before edge n is captured into stage[0] at edge n.
  - It appears on SYNC just after edge n+NUM_STAGES-1, i.e. NUM_STAGES edges including the capture edge.
  - Worst case from an asynchronous change to SYNC is NUM_STAGES+1 cycles.
- Releasing reset: deassert RST before edge r. ASYNC sampled at edge r reaches SYNC after edge r+NUM_STAGES-1. Until then SYNC = RESET_VALUE.
- Reset mid-operation: any edge with RST=1 clears the whole pipeline. In-flight values are discarded, not delivered.
- Pulses shorter than one CLK period on ASYNC may be lost. This is required, documented behaviour.
- A metastable stage[0] must resolve to 0 or 1. SYNC never shows X once the block has left reset.

## Configuration
- Macro MULTI_FLOP_SYNC_EDGE_EN.
- Defined:
  - A history register prev <= SYNC is added.
  - RISE = SYNC & ~prev and FALL = ~SYNC & prev are added.
  - Both outputs are registered-source combinational, one cycle wide, aligned to the first cycle SYNC shows the new value.
  - The first cycle after reset has RISE=FALL=0, because prev = RESET_VALUE.
- Undefined: RISE, FALL and prev are absent from the port list and from the netlist. SYNC behaviour is identical in both builds.

## Test plan
- Reset: NUM_STAGES=2, BUS_WIDTH=1, RST=1, ASYNC=1 for 1 edge -> SYNC=0.
- Propagation: NUM_STAGES=2, BUS_WIDTH=1, RST=1 for 1 edge with ASYNC=1, then RST=0 for 2 edges -> SYNC=1.
  - Also check SYNC=0 after only 1 edge.
- Latency sweep: NUM_STAGES=3, BUS_WIDTH=8, ASYNC=8'hA5 before edge n -> SYNC=8'h00 through edge n+1, SYNC=8'hA5 after edge n+2.
- Mid-stream reset: NUM_STAGES=3, ASYNC=8'hFF in flight, RST=1 for one edge -> SYNC=8'h00 on the next cycle.
  - After release, 8'hFF returns after 3 edges.
- Edge outputs (macro defined): ASYNC 0->1 -> RISE=1 for exactly one cycle, coincident with SYNC becoming 1.
  - ASYNC 1->0 -> FALL=1 for one cycle.
  - Neither pulses right after reset.
- RESET_VALUE=4'b1010, BUS_WIDTH=4, RST=1 for 1 edge -> SYNC=4'b1010.
  - Then ASYNC=4'b0101 with RST=0 -> SYNC=4'b0101 after NUM_STAGES edges.
